mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Main control FSM for the lab3 multicycle MIPS datapath.
- Sequences the datapath's architectural flops (PC, IR, register file, memory) by driving their enables and mux selects, one state per cycle.
- Waits on a memory-ready handshake and aborts a memory access on timeout.
- Sits beside the datapath and takes the opcode from IR and the zero flag from the ALU.

Parameters:
TIMEOUT, 15, maximum wait cycles for mem_ready in a memory state; 0 disables the timeout.
CW, 4, width of the wait counter; must satisfy 2^CW > TIMEOUT.

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
op  input  6  opcode, IR[31:26]
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes current access this cycle
mem_req  output  1  memory access request
memwrite  output  1  write strobe, valid with mem_req
iord  output  1  memory address select: 0 = PC, 1 = ALUOut
irwrite  output  1  IR load enable
pcen  output  1  PC load enable, equals pcwrite OR (branch AND zero)
regwrite  output  1  register file write enable
regdst  output  1  destination select: 0 = rt, 1 = rd
memtoreg  output  1  writeback source: 0 = ALUOut, 1 = MDR
alusrca  output  1  ALU A: 0 = PC, 1 = rs
alusrcb  output  2  ALU B: 00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
aluop  output  2  00 = add, 01 = sub, 10 = funct-decoded
pcsrc  output  2  00 = ALU, 01 = ALUOut, 10 = jump target
illegal_op  output  1  one-cycle pulse, unknown opcode decoded
mem_timeout  output  1  one-cycle pulse, memory wait aborted

Behaviour:
- reset low (asynchronous): state = IDLE, wait counter = 0. All outputs are 0 while reset is low and while in IDLE.
- IDLE -> FETCH unconditionally on the first edge after reset releases.
- Outputs are Moore-decoded from state. Exceptions:
  - pcen depends on zero.
  - FETCH irwrite/pcwrite are gated by mem_ready.
  - pulses come from registered flags.
- Unlisted outputs are 0 in every state.
- FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00; irwrite=pcwrite=mem_ready. Exits to DECODE on mem_ready, else stays.
- DECODE: alusrca=0, alusrcb=11, aluop=00. Next state by op:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 -> RTYPEEX
  - 000100 -> BEQEX
  - 001000 -> ADDIEX
  - 000010 -> JEX
  - other -> FETCH, with illegal_op=1 the next cycle.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_req=1, iord=1. mem_ready -> MEMWB.
- MEMWB: regwrite=1, regdst=0, memtoreg=1. -> FETCH.
- MEMWR: mem_req=1, memwrite=1, iord=1. mem_ready -> FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=10. -> ALUWB.
- ALUWB: regwrite=1, regdst=1, memtoreg=0. -> FETCH.
- BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1, so pcen=zero. -> FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. -> ADDIWB.
- ADDIWB: regwrite=1, regdst=0, memtoreg=0. -> FETCH.
- JEX: pcsrc=10, pcwrite=1. -> FETCH.
- Latency, zero wait states: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.
- Wait counter (FETCH, MEMRD, MEMWR):
  - Cleared on state entry; increments each cycle mem_ready=0.
  - TIMEOUT>0 and count reaches TIMEOUT with mem_ready=0: next state FETCH, mem_timeout=1 for one cycle, no writes that cycle. FETCH aborting to FETCH restarts the counter.
  - mem_ready=1 on the same cycle the count reaches TIMEOUT: the access completes and there is no timeout.
- mem_ready is ignored outside the memory states.
- The counter saturates; it never wraps.
- A reset assertion mid-instruction forces IDLE immediately and all outputs drop to 0 in the same cycle.

Decomposition:
- Package mips_pkg holds:
  - opcode constants (OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J)
  - state enum
  - ALUSRCB_*, PCSRC_*, ALUOP_* encodings
  - a control-word struct.
- Sub-module mc_outdec: combinational state-to-control-word decoder.
- mc_controller holds the state register, next-state logic, wait counter, pulse flags and pcen gating.

Test Plan:
- Reset low 3 cycles, release, mem_ready=1 constant -> all outputs 0 through IDLE; FETCH next cycle with mem_req=1, irwrite=1, pcen=1.
- op=100011, mem_ready=1 -> state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 and memtoreg=1 only in cycle 5; next cycle is FETCH.
- op=000100 with zero=1, then zero=0 -> BEQEX pcen=1 with pcsrc=01 in the first case; pcen=0 in the second.
- op=101011, mem_ready held 0 in MEMWR, TIMEOUT=15 -> memwrite held 15 cycles, mem_timeout pulses once, return to FETCH; ready on count 15 -> normal completion, no pulse.
- op=111111 -> illegal_op=1 for exactly one cycle, then FETCH; no regwrite/pcen beyond the FETCH cycles.
- Reset asserted mid-MEMRD (asynchronous, between edges) -> mem_req falls immediately; after release, IDLE then FETCH.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the lab3 multicycle MIPS controller: opcodes, FSM states,
// datapath select encodings and the decoded control word.
package mips_pkg;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUSRCB_RT    = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_RTYPEEX, S_ALUWB, S_BEQEX, S_ADDIEX, S_ADDIWB, S_JEX
    } state_t;

    // ready_gated: irwrite/pcwrite only take effect on a mem_ready cycle
    typedef struct packed {
        logic       mem_req;
        logic       memwrite;
        logic       iord;
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       ready_gated;
    } ctrl_t;

    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mc_outdec.sv
// Moore decode of controller state into the datapath control word.
module mc_outdec
    import mips_pkg::*;
(
    input  state_t state,
    output ctrl_t  cw
);

    always_comb begin
        cw = '0;
        case (state)
            S_FETCH: begin
                cw.mem_req     = 1'b1;
                cw.irwrite     = 1'b1;
                cw.pcwrite     = 1'b1;
                cw.ready_gated = 1'b1;
                cw.alusrcb     = ALUSRCB_FOUR;
                cw.aluop       = ALUOP_ADD;
                cw.pcsrc       = PCSRC_ALU;
            end
            S_DECODE: begin
                cw.alusrcb = ALUSRCB_IMMSH;
                cw.aluop   = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                cw.alusrca = 1'b1;
                cw.alusrcb = ALUSRCB_IMM;
                cw.aluop   = ALUOP_ADD;
            end
            S_MEMRD: begin
                cw.mem_req = 1'b1;
                cw.iord    = 1'b1;
            end
            S_MEMWB: begin
                cw.regwrite = 1'b1;
                cw.memtoreg = 1'b1;
            end
            S_MEMWR: begin
                cw.mem_req  = 1'b1;
                cw.memwrite = 1'b1;
                cw.iord     = 1'b1;
            end
            S_RTYPEEX: begin
                cw.alusrca = 1'b1;
                cw.alusrcb = ALUSRCB_RT;
                cw.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                cw.regwrite = 1'b1;
                cw.regdst   = 1'b1;
            end
            S_BEQEX: begin
                cw.alusrca = 1'b1;
                cw.alusrcb = ALUSRCB_RT;
                cw.aluop   = ALUOP_SUB;
                cw.pcsrc   = PCSRC_ALUOUT;
                cw.branch  = 1'b1;
            end
            S_ADDIWB: cw.regwrite = 1'b1;
            S_JEX: begin
                cw.pcsrc   = PCSRC_JUMP;
                cw.pcwrite = 1'b1;
            end
            default: cw = '0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Main control FSM for the multicycle MIPS datapath: state sequencing,
// memory wait counter with timeout abort, and event pulse flags.
module mc_controller
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CW      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       pcen,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic       illegal_op,
    output logic       mem_timeout
);

    localparam logic [CW:0] TO_LIM = TIMEOUT[CW:0];

    state_t        state, state_nx;
    ctrl_t         cw;
    logic [CW-1:0] wcnt;
    logic [CW:0]   wcnt_inc;
    logic          illegal_nx, timeout_hit;
    logic          illegal_flag, timeout_flag;
    logic          ready_ok;

    mc_outdec u_outdec (
        .state (state),
        .cw    (cw)
    );

    // Abort on the cycle whose wait would make the count reach TIMEOUT.
    assign wcnt_inc    = {1'b0, wcnt} + 1'b1;
    assign timeout_hit = is_mem_state(state) && !mem_ready &&
                         (TIMEOUT != 0) && (wcnt_inc == TO_LIM);

    always_comb begin
        state_nx   = state;
        illegal_nx = 1'b0;
        case (state)
            S_IDLE:   state_nx = S_FETCH;
            S_FETCH:  if (mem_ready) state_nx = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_nx = S_MEMADR;
                    OP_RTYPE:     state_nx = S_RTYPEEX;
                    OP_BEQ:       state_nx = S_BEQEX;
                    OP_ADDI:      state_nx = S_ADDIEX;
                    OP_J:         state_nx = S_JEX;
                    default: begin
                        state_nx   = S_FETCH;
                        illegal_nx = 1'b1;
                    end
                endcase
            end
            S_MEMADR:  state_nx = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (mem_ready) state_nx = S_MEMWB;
            S_MEMWR:   if (mem_ready) state_nx = S_FETCH;
            S_RTYPEEX: state_nx = S_ALUWB;
            S_ADDIEX:  state_nx = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BEQEX, S_ADDIWB, S_JEX: state_nx = S_FETCH;
            default:   state_nx = S_IDLE;
        endcase
        if (timeout_hit) state_nx = S_FETCH;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            wcnt         <= '0;
            illegal_flag <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            state        <= state_nx;
            illegal_flag <= illegal_nx;
            timeout_flag <= timeout_hit;
            // A FETCH->FETCH abort counts as a fresh entry.
            if (timeout_hit || (state_nx != state))
                wcnt <= '0;
            else if (is_mem_state(state) && !mem_ready && (wcnt != '1))
                wcnt <= wcnt + 1'b1;
        end
    end

    assign ready_ok    = !cw.ready_gated || mem_ready;
    assign mem_req     = cw.mem_req;
    assign memwrite    = cw.memwrite;
    assign iord        = cw.iord;
    assign irwrite     = cw.irwrite & ready_ok;
    assign pcen        = (cw.pcwrite & ready_ok) | (cw.branch & zero);
    assign regwrite    = cw.regwrite;
    assign regdst      = cw.regdst;
    assign memtoreg    = cw.memtoreg;
    assign alusrca     = cw.alusrca;
    assign alusrcb     = cw.alusrcb;
    assign aluop       = cw.aluop;
    assign pcsrc       = cw.pcsrc;
    assign illegal_op  = illegal_flag;
    assign mem_timeout = timeout_flag;

endmodule

// File: tb/tb_mc_controller.sv
// Randomized bench for mc_controller against an instruction-step table model.
module tb_mc_controller;

    localparam int TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic       illegal_op, mem_timeout;

    mc_controller #(.TIMEOUT(TIMEOUT), .CW(4)) dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
        .pcen(pcen), .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
        .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc),
        .illegal_op(illegal_op), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    // One instruction step: mem iord... fields follow the datapath's view
    typedef struct packed {
        logic mem, memreq, memwrite, iord, irw, pcw, br, regw, regdst, m2r, asa;
        logic [1:0] asb, aop, psrc;
    } step_t;

    //                              m r w i i p b r d t a asb aop ps
    localparam step_t FETCH_S  = 17'b1_1_0_0_1_1_0_0_0_0_0_01_00_00;
    localparam step_t DECODE_S = 17'b0_0_0_0_0_0_0_0_0_0_0_11_00_00;
    localparam step_t ADDR_S   = 17'b0_0_0_0_0_0_0_0_0_0_1_10_00_00;
    localparam step_t RD_S     = 17'b1_1_0_1_0_0_0_0_0_0_0_00_00_00;
    localparam step_t LDWB_S   = 17'b0_0_0_0_0_0_0_1_0_1_0_00_00_00;
    localparam step_t WR_S     = 17'b1_1_1_1_0_0_0_0_0_0_0_00_00_00;
    localparam step_t REX_S    = 17'b0_0_0_0_0_0_0_0_0_0_1_00_10_00;
    localparam step_t RWB_S    = 17'b0_0_0_0_0_0_0_1_1_0_0_00_00_00;
    localparam step_t BEQ_S    = 17'b0_0_0_0_0_0_1_0_0_0_1_00_01_01;
    localparam step_t IWB_S    = 17'b0_0_0_0_0_0_0_1_0_0_0_00_00_00;
    localparam step_t J_S      = 17'b0_0_0_0_0_1_0_0_0_0_0_00_00_10;

    int         n_checks = 0, n_errors = 0;
    bit         idle = 1'b1;
    step_t      q[$];
    int         waited = 0;
    bit         exp_ill = 1'b0, exp_to = 1'b0;
    logic [5:0] next_op = 6'd0;
    logic [5:0] script[$];
    int         fetches = 0;
    int         rmode = 1;        // 0 always ready, 1 random, 2 data never ready, 3 ready on 15th wait
    int         zero_force = -1;
    int         wr_run = 0, last_wr_run = 0, to_pulses = 0, ill_pulses = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] pick_op();
        logic [5:0] v;
        if (script.size() > 0) return script.pop_front();
        case ($urandom_range(0, 7))
            0: v = 6'b100011;
            1: v = 6'b101011;
            2: v = 6'b000000;
            3: v = 6'b000100;
            4: v = 6'b001000;
            5: v = 6'b000010;
            6: v = 6'b100011;
            default: begin
                v = 6'($urandom);
                if (v inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010})
                    v = 6'b111111;
            end
        endcase
        return v;
    endfunction

    task automatic start_instr();
        q.delete();
        q.push_back(FETCH_S);
        q.push_back(DECODE_S);
        waited  = 0;
        next_op = pick_op();
    endtask

    task automatic enqueue_for(input logic [5:0] o);
        case (o)
            6'b100011: begin q.push_back(ADDR_S); q.push_back(RD_S); q.push_back(LDWB_S); end
            6'b101011: begin q.push_back(ADDR_S); q.push_back(WR_S); end
            6'b000000: begin q.push_back(REX_S);  q.push_back(RWB_S); end
            6'b000100: q.push_back(BEQ_S);
            6'b001000: begin q.push_back(ADDR_S); q.push_back(IWB_S); end
            6'b000010: q.push_back(J_S);
            default:   exp_ill = 1'b1;
        endcase
    endtask

    task automatic model_step();
        step_t cur;
        exp_ill = 1'b0;
        exp_to  = 1'b0;
        if (!reset) begin
            idle = 1'b1;
            q.delete();
            return;
        end
        if (idle) begin
            idle = 1'b0;
            start_instr();
            return;
        end
        cur = q[0];
        if (cur.mem && !mem_ready) begin
            waited++;
            if (TIMEOUT > 0 && waited == TIMEOUT) begin
                exp_to = 1'b1;
                start_instr();
            end
        end else begin
            waited = 0;
            void'(q.pop_front());
            if (cur == FETCH_S) fetches++;
            if (cur == DECODE_S) enqueue_for(op);
            if (q.size() == 0) start_instr();
        end
    endtask

    function automatic logic [16:0] observed();
        return {mem_req, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg,
                alusrca, alusrcb, aluop, pcsrc, illegal_op, mem_timeout};
    endfunction

    task automatic compare_cycle();
        step_t s;
        logic gate;
        logic [16:0] exp;
        if (idle) begin
            exp = '0;
        end else begin
            s    = q[0];
            gate = !s.mem || mem_ready;
            exp  = {s.memreq, s.memwrite, s.iord, s.irw & gate, (s.pcw & gate) | (s.br & zero),
                    s.regw, s.regdst, s.m2r, s.asa, s.asb, s.aop, s.psrc, exp_ill, exp_to};
        end
        chk("ctrl", {15'd0, observed()}, {15'd0, exp});
        if (memwrite) wr_run++;
        else if (wr_run > 0) begin last_wr_run = wr_run; wr_run = 0; end
        if (mem_timeout) to_pulses++;
        if (illegal_op) ill_pulses++;
    endtask

    task automatic drive(input bit release_rst);
        if (release_rst) reset = 1'b1;
        op   = next_op;
        zero = (zero_force >= 0) ? zero_force[0] : 1'($urandom_range(0, 1));
        if (rmode == 0) mem_ready = 1'b1;
        else if (!idle && q.size() > 0 && q[0].mem) begin
            if (q[0] == FETCH_S) mem_ready = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            else case (rmode)
                1:       mem_ready = 1'($urandom_range(0, 1));
                2:       mem_ready = 1'b0;
                default: mem_ready = (waited == TIMEOUT - 1);
            endcase
        end else mem_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic cycle(input bit release_rst);
        @(posedge clk);
        #1;
        drive(release_rst);
        @(negedge clk);
        compare_cycle();
        model_step();
    endtask

    task automatic run_instrs(input int n);
        int target, budget;
        target = fetches + n;
        budget = n * 60 + 20;
        while (fetches < target && budget > 0) begin
            cycle(1'b0);
            budget--;
        end
        if (fetches < target) chk("instr_budget", fetches, target);
    endtask

    initial begin
        int p0;
        bit hit;
        #2 reset = 1'b0;
        rmode = 0;
        script.push_back(6'b100011);
        script.push_back(6'b000010);
        for (int i = 0; i < 3; i++) cycle(1'b0);
        cycle(1'b1);
        run_instrs(2);

        zero_force = 1;
        script.push_back(6'b000100); script.push_back(6'b000010);
        run_instrs(2);
        zero_force = 0;
        script.push_back(6'b000100); script.push_back(6'b000010);
        run_instrs(2);
        zero_force = -1;

        rmode = 2; p0 = to_pulses;
        script.push_back(6'b101011); script.push_back(6'b000010);
        run_instrs(2);
        chk("to_wr_len", last_wr_run, TIMEOUT);
        chk("to_pulse_cnt", to_pulses - p0, 1);

        rmode = 3; p0 = to_pulses;
        script.push_back(6'b101011); script.push_back(6'b000010);
        run_instrs(2);
        chk("rdy15_wr_len", last_wr_run, TIMEOUT);
        chk("rdy15_no_pulse", to_pulses - p0, 0);

        rmode = 0; p0 = ill_pulses;
        script.push_back(6'b111111); script.push_back(6'b000010);
        run_instrs(2);
        chk("illegal_pulse_cnt", ill_pulses - p0, 1);

        rmode = 1;
        run_instrs(300);

        rmode = 2;
        script.push_back(6'b100011);
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            cycle(1'b0);
            if (!idle && q.size() > 0 && q[0] == RD_S && waited >= 2) hit = 1'b1;
        end
        chk("reach_memrd", {31'd0, hit}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("rst_memreq", {31'd0, mem_req}, 32'd0);
        chk("rst_outputs", {15'd0, observed()}, 32'd0);
        idle = 1'b1; q.delete(); exp_ill = 1'b0; exp_to = 1'b0;
        rmode = 1;
        cycle(1'b0);
        cycle(1'b0);
        cycle(1'b1);
        run_instrs(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
